bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares one single-port, byte-writable block RAM (1-cycle read latency, bit-granular write mask, always-ready) between two requesters.
- Typical pairing: port 0 is the CPU data or instruction bus; port 1 is a DMA or debug loader.
- Performs per-cycle arbitration, expands byte enables to the RAM's bit-mask strobe, and routes each 1-cycle-late read response back to its owner.
- Sits between the subsystem interconnect and the RAM model instance.

Parameters:
- DATA_WIDTH, 32, RAM word width in bits; must be a multiple of 8.
- RAM_DEPTH, 1024, words; address width AW = $clog2(RAM_DEPTH).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 always wins).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- p0_req_valid  in  1  port 0 request present.
- p0_req_ready  out  1  port 0 request accepted this cycle.
- p0_addr  in  AW  word address.
- p0_we  in  1  1 = write, 0 = read.
- p0_be  in  DATA_WIDTH/8  byte enables; used for writes only.
- p0_wdata  in  DATA_WIDTH  write data.
- p0_rvalid  out  1  read data valid.
- p0_rdata  out  DATA_WIDTH  read data.
- p1_*  same set as p0_*, for port 1.
- ram_cs  out  1  RAM chip select.
- ram_addr  out  AW  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wstrb  out  DATA_WIDTH  RAM bit-level write mask.
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_dout  in  DATA_WIDTH  RAM read data, valid 1 cycle after a read select.
- ram_ready  in  1  RAM can accept this cycle.

Behaviour:
- Arbitration (combinational, same cycle):
  - Accept condition: at most one request is accepted per cycle, and only if ram_ready=1.
  - One port valid: that port is granted.
  - Both ports valid, ARB_MODE=0: grant the port not recorded in last_grant.
  - Both ports valid, ARB_MODE=1: grant port 0.
- Grant register:
  - last_grant updates to the granted port only on an accepted request.
  - last_grant reset value is 1, so port 0 wins the first contention.
- Handshake:
  - pN_req_ready = grantN & ram_ready.
  - A request transfers when valid & ready are both 1.
  - Requester must hold addr/we/be/wdata stable while valid=1 and ready=0.
  - Dropping valid before acceptance is permitted.
- RAM drive:
  - ram_cs = accepted.
  - ram_addr, ram_we and ram_din come from the granted port.
  - When ram_cs=0, ram_addr, ram_we and ram_din are driven to 0.
- Strobe expansion:
  - ram_wstrb[8*k+7 : 8*k] = {8{be[k]}} when the granted port's we=1.
  - ram_wstrb is all-zero for reads and when idle.
- Read response:
  - On an accepted read in cycle T, register rd_pend=1 and rd_owner=port.
  - In cycle T+1, p<rd_owner>_rvalid=1 for exactly one cycle, with rdata = ram_dout.
  - Back-to-back reads from alternating ports produce alternating rvalid pulses with no bubble.
  - Writes produce no response.
- rdata:
  - pN_rdata is ram_dout when pN_rvalid=1, otherwise 0.
  - The two ports never share rvalid in the same cycle.
- Simultaneous events:
  - A write accepted in cycle T+1 while the read from cycle T returns is legal; both happen.
  - A read of an address written in the previous cycle returns the new data, relying on the RAM's ordering.
- ram_ready=0: no acceptance occurs; last_grant and pending state are held; an already-pending rvalid still fires.
- Reset (also when asserted mid-operation):
  - rd_pend=0 and last_grant=1.
  - All req_ready and rvalid outputs are 0 in the cycle rst is high and in the cycle after.
  - A read accepted in the cycle before rst asserts gets no response; it is discarded.
  - Outputs while rst=1: ram_cs=0, ram_we=0, ram_wstrb=0, ram_addr=0, ram_din=0, rdata=0.
  - No request is accepted while rst=1.

Decomposition:
- Package bram_arb_pkg:
  - typedef port_id_t (1 bit).
  - Constants ARB_RR=0 and ARB_FIXED=1.
  - Function be_to_bitmask(be) for strobe expansion.
- One sub-module: bram_rr_arb2.
  - Holds the 2-way round-robin/fixed-priority grant logic and the last_grant register.
  - Inputs: req[1:0], advance, mode. Output: one-hot gnt[1:0].
- The top level holds the response tracker, RAM muxing and strobe expansion.

Test Plan:
- Single read: p0 read addr 0x010, RAM preloaded 0xDEADBEEF -> p0_req_ready=1 in T; p0_rvalid=1 with rdata=0xDEADBEEF in T+1; p1_rvalid=0.
- Byte write: p1 write addr 0x020, be=4'b0101, wdata=0xAABBCCDD over 0x11223344 -> ram_wstrb=0x00FF00FF; subsequent read returns 0x11BB33DD.
- Contention, ARB_MODE=0: both ports read continuously for 6 cycles -> grants alternate p0,p1,p0,p1,p0,p1; each port gets 3 rvalid pulses, each one cycle after its grant.
- Contention, ARB_MODE=1: both ports valid for 4 cycles -> p0 granted every cycle, p1_req_ready stays 0; p1 granted in the first cycle after p0 drops valid.
- Backpressure: ram_ready=0 for 3 cycles with p0 valid -> no ram_cs and p0_req_ready=0; acceptance in the first cycle ram_ready=1; pending rvalid issued before the stall still delivered.
- Reset mid-read: p0 read accepted in T, rst=1 in T+1 -> p0_rvalid=0 in T+1 and T+2; after release, p0 wins the first p0/p1 contention.

Source files
------------

// File: rtl/bram_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : bram_arb_pkg                                                  |
// | Purpose  : Shared types, constants and helpers for the two-port block    |
// |            RAM arbiter (port identifiers, arbitration modes, byte-enable |
// |            to bit-mask expansion).                                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package bram_arb_pkg;

  // Identifies one of the two requesters.
  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  // Arbitration modes.
  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  // Widest byte-enable vector the strobe helper handles. Callers size-cast
  // the argument up and the result down to their own data width.
  localparam int BE_MAX = 64;

  // Expands each byte enable into eight identical mask bits.
  function automatic logic [8*BE_MAX-1:0] be_to_bitmask(input logic [BE_MAX-1:0] be);
    logic [8*BE_MAX-1:0] mask;
    mask = '0;
    for (int k = 0; k < BE_MAX; k++) begin
      mask[8*k +: 8] = {8{be[k]}};
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: bram_port_arbiter_if                                          |
// | Purpose  : Bundles both requester ports and the RAM-side signals of the  |
// |            arbiter.                                                      |
// | Ports    : pN_req_valid/ready, pN_addr, pN_we, pN_be, pN_wdata,          |
// |            pN_rvalid, pN_rdata (N = 0,1); ram_cs, ram_addr, ram_we,      |
// |            ram_wstrb, ram_din, ram_dout, ram_ready.                      |
// |            slave  = arbiter view, master = requesters + RAM view.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface bram_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 1024
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int BW = DATA_WIDTH / 8;

  logic                  p0_req_valid;
  logic                  p0_req_ready;
  logic [AW-1:0]         p0_addr;
  logic                  p0_we;
  logic [BW-1:0]         p0_be;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_rvalid;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_req_valid;
  logic                  p1_req_ready;
  logic [AW-1:0]         p1_addr;
  logic                  p1_we;
  logic [BW-1:0]         p1_be;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_rvalid;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic                  ram_cs;
  logic [AW-1:0]         ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wstrb;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  ram_ready;

  modport slave (
    input  p0_req_valid, p0_addr, p0_we, p0_be, p0_wdata,
    output p0_req_ready, p0_rvalid, p0_rdata,
    input  p1_req_valid, p1_addr, p1_we, p1_be, p1_wdata,
    output p1_req_ready, p1_rvalid, p1_rdata,
    output ram_cs, ram_addr, ram_we, ram_wstrb, ram_din,
    input  ram_dout, ram_ready
  );

  modport master (
    output p0_req_valid, p0_addr, p0_we, p0_be, p0_wdata,
    input  p0_req_ready, p0_rvalid, p0_rdata,
    output p1_req_valid, p1_addr, p1_we, p1_be, p1_wdata,
    input  p1_req_ready, p1_rvalid, p1_rdata,
    input  ram_cs, ram_addr, ram_we, ram_wstrb, ram_din,
    output ram_dout, ram_ready
  );

endinterface
`default_nettype wire

// File: rtl/bram_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bram_rr_arb2                                                  |
// | Purpose  : Two-way grant logic, round-robin or fixed priority, with the  |
// |            last-grant history register.                                  |
// | Ports    : clk, rst      - clock, synchronous active-high reset          |
// |            req[1:0]      - request per port                              |
// |            advance       - a grant was consumed; record it               |
// |            mode          - ARB_RR or ARB_FIXED                           |
// |            gnt[1:0]      - one-hot grant (zero when no request)          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bram_rr_arb2
  import bram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       mode,
  output logic [1:0] gnt
);

  port_id_t r_last_grant;

  // Resetting to port 1 makes port 0 the winner of the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= PORT1;
    end else if (advance) begin
      r_last_grant <= gnt[1];
    end
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      if ((mode == ARB_FIXED) || (r_last_grant == PORT1)) begin
        gnt = 2'b01;
      end else begin
        gnt = 2'b10;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bram_port_arbiter                                             |
// | Purpose  : Shares one single-port byte-writable block RAM between two    |
// |            requesters: per-cycle arbitration, byte-enable to bit-strobe  |
// |            expansion and routing of the 1-cycle-late read data.          |
// | Ports    : clk, rst - clock, synchronous active-high reset               |
// |            bus      - bram_port_arbiter_if.slave (both requester ports   |
// |                       and the RAM-side signals)                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 1024,
  parameter int ARB_MODE   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  bram_port_arbiter_if.slave        bus
);

  localparam int   AW         = $clog2(RAM_DEPTH);
  localparam int   BW         = DATA_WIDTH / 8;
  localparam logic c_arb_mode = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

  logic                  r_rst_q;
  logic                  r_rd_pend;
  port_id_t              r_rd_owner;

  logic                  w_open;
  logic                  w_accept;
  logic [1:0]            w_gnt;
  port_id_t              w_sel;
  logic [AW-1:0]         w_sel_addr;
  logic                  w_sel_we;
  logic [BW-1:0]         w_sel_be;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_rvalid0;
  logic                  w_rvalid1;

  bram_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({bus.p1_req_valid, bus.p0_req_valid}),
    .advance (w_accept),
    .mode    (c_arb_mode),
    .gnt     (w_gnt)
  );

  // Acceptance is closed while reset is high and for the cycle right after,
  // so the requesters always see a quiet cycle when coming out of reset.
  assign w_open   = ~rst & ~r_rst_q;
  assign w_accept = (|w_gnt) & bus.ram_ready & w_open;
  assign w_sel    = w_gnt[1] ? PORT1 : PORT0;

  assign bus.p0_req_ready = w_gnt[0] & bus.ram_ready & w_open;
  assign bus.p1_req_ready = w_gnt[1] & bus.ram_ready & w_open;

  always_comb begin
    w_sel_addr  = bus.p0_addr;
    w_sel_we    = bus.p0_we;
    w_sel_be    = bus.p0_be;
    w_sel_wdata = bus.p0_wdata;
    if (w_sel == PORT1) begin
      w_sel_addr  = bus.p1_addr;
      w_sel_we    = bus.p1_we;
      w_sel_be    = bus.p1_be;
      w_sel_wdata = bus.p1_wdata;
    end
  end

  // RAM side is forced to zero whenever nothing is accepted.
  always_comb begin
    bus.ram_cs    = w_accept;
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_din   = '0;
    bus.ram_wstrb = '0;
    if (w_accept) begin
      bus.ram_addr = w_sel_addr;
      bus.ram_we   = w_sel_we;
      bus.ram_din  = w_sel_wdata;
      if (w_sel_we) begin
        bus.ram_wstrb = DATA_WIDTH'(be_to_bitmask(BE_MAX'(w_sel_be)));
      end
    end
  end

  // Read response tracker: one outstanding read at most, since the RAM
  // answers exactly one cycle after the select.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_q    <= 1'b1;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= PORT0;
    end else begin
      r_rst_q   <= 1'b0;
      r_rd_pend <= w_accept & ~w_sel_we;
      if (w_accept) begin
        r_rd_owner <= w_sel;
      end
    end
  end

  // Gating with rst discards a read accepted the cycle before reset.
  assign w_rvalid0 = r_rd_pend & ~rst & (r_rd_owner == PORT0);
  assign w_rvalid1 = r_rd_pend & ~rst & (r_rd_owner == PORT1);

  assign bus.p0_rvalid = w_rvalid0;
  assign bus.p1_rvalid = w_rvalid1;
  assign bus.p0_rdata  = w_rvalid0 ? bus.ram_dout : '0;
  assign bus.p1_rdata  = w_rvalid1 ? bus.ram_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bram_port_arbiter                                          |
// | Purpose  : Self-checking bench for bram_port_arbiter: behavioural RAM,   |
// |            reference memory, read-response scoreboard and a grant model; |
// |            a second instance in fixed-priority mode shares the stimulus. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bram_port_arbiter;

  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int BW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_port_arbiter_if #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) bus ();
  bram_port_arbiter_if #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) bus_f ();

  bram_port_arbiter #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .ARB_MODE(0)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  bram_port_arbiter #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .ARB_MODE(1)) dut_f (
    .clk (clk), .rst (rst), .bus (bus_f)
  );

  // Fixed-priority instance mirrors the main stimulus.
  assign bus_f.p0_req_valid = bus.p0_req_valid;
  assign bus_f.p0_addr      = bus.p0_addr;
  assign bus_f.p0_we        = bus.p0_we;
  assign bus_f.p0_be        = bus.p0_be;
  assign bus_f.p0_wdata     = bus.p0_wdata;
  assign bus_f.p1_req_valid = bus.p1_req_valid;
  assign bus_f.p1_addr      = bus.p1_addr;
  assign bus_f.p1_we        = bus.p1_we;
  assign bus_f.p1_be        = bus.p1_be;
  assign bus_f.p1_wdata     = bus.p1_wdata;
  assign bus_f.ram_ready    = bus.ram_ready;
  assign bus_f.ram_dout     = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mask_of(input logic [BW-1:0] be);
    logic [DW-1:0] m;
    m = '0;
    for (int k = 0; k < BW; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  // Behavioural RAM plus the bench's reference copy of its contents.
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
    ram_mem[32] = 32'h11223344; ref_mem[32] = 32'h11223344;
    bus.ram_dout = '0;
    forever begin
      @(posedge clk);
      if (bus.ram_cs) begin
        if (bus.ram_we)
          ram_mem[bus.ram_addr] = (ram_mem[bus.ram_addr] & ~bus.ram_wstrb) | (bus.ram_din & bus.ram_wstrb);
        else
          bus.ram_dout = ram_mem[bus.ram_addr];
      end
    end
  end

  // Scoreboard: expected read responses, pushed at acceptance.
  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  exp_t          e;
  logic [1:0]    m_acc, m_valid, m_eg;
  logic          m_port, m_we, m_last, rst_d, m_open;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_wd, m_mask;

  initial begin
    m_last = 1'b1;
    rst_d  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_last = 1'b1;
        check_val("rst_ready",  {bus.p1_req_ready, bus.p0_req_ready}, 0);
        check_val("rst_rvalid", {bus.p1_rvalid, bus.p0_rvalid}, 0);
        check_val("rst_ram_ctl", {bus.ram_cs, bus.ram_we, bus.ram_addr}, 0);
        check_val("rst_ram_data", {bus.ram_wstrb, bus.ram_din}, 0);
        check_val("rst_rdata", {bus.p1_rdata, bus.p0_rdata}, 0);
        rst_d = 1'b1;
      end else begin
        m_open = ~rst_d;
        if (rst_d) begin
          check_val("post_rst_ready",  {bus.p1_req_ready, bus.p0_req_ready}, 0);
          check_val("post_rst_rvalid", {bus.p1_rvalid, bus.p0_rvalid}, 0);
        end
        rst_d = 1'b0;
        // Responses
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          check_val("rvalid", {bus.p1_rvalid, bus.p0_rvalid}, e.port ? 2'b10 : 2'b01);
          check_val("rdata", e.port ? bus.p1_rdata : bus.p0_rdata, e.data);
          check_val("rdata_other", e.port ? bus.p0_rdata : bus.p1_rdata, 0);
        end else begin
          check_val("no_rvalid", {bus.p1_rvalid, bus.p0_rvalid}, 0);
          check_val("no_rdata", {bus.p1_rdata, bus.p0_rdata}, 0);
        end
        // Grant model
        m_valid = {bus.p1_req_valid, bus.p0_req_valid};
        m_acc   = {bus.p1_req_valid & bus.p1_req_ready, bus.p0_req_valid & bus.p0_req_ready};
        if (!bus.ram_ready || !m_open) m_eg = 2'b00;
        else if (m_valid == 2'b11)     m_eg = m_last ? 2'b01 : 2'b10;
        else                           m_eg = m_valid;
        check_val("grant", m_acc, m_eg);
        check_val("ready_idle", {bus.p1_req_ready & ~bus.p1_req_valid, bus.p0_req_ready & ~bus.p0_req_valid}, 0);
        // RAM drive
        if (m_acc != 2'b00) begin
          m_port = m_acc[1];
          m_last = m_port;
          m_addr = m_port ? bus.p1_addr  : bus.p0_addr;
          m_we   = m_port ? bus.p1_we    : bus.p0_we;
          m_be   = m_port ? bus.p1_be    : bus.p0_be;
          m_wd   = m_port ? bus.p1_wdata : bus.p0_wdata;
          m_mask = m_we ? mask_of(m_be) : '0;
          check_val("ram_cs", bus.ram_cs, 1);
          check_val("ram_addr", bus.ram_addr, m_addr);
          check_val("ram_we", bus.ram_we, m_we);
          check_val("ram_wstrb", bus.ram_wstrb, m_mask);
          check_val("ram_din", bus.ram_din, m_wd);
          if (m_we) ref_mem[m_addr] = (ref_mem[m_addr] & ~m_mask) | (m_wd & m_mask);
          else      exp_q.push_back('{port: m_port, data: ref_mem[m_addr], due: cyc + 1});
        end else begin
          check_val("ram_idle_ctl", {bus.ram_cs, bus.ram_we, bus.ram_addr}, 0);
          check_val("ram_idle_data", {bus.ram_wstrb, bus.ram_din}, 0);
        end
      end
    end
  end

  task automatic drive(input bit p, input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] wd);
    if (!p) begin
      bus.p0_req_valid = v; bus.p0_we = we; bus.p0_addr = a; bus.p0_be = be; bus.p0_wdata = wd;
    end else begin
      bus.p1_req_valid = v; bus.p1_we = we; bus.p1_addr = a; bus.p1_be = be; bus.p1_wdata = wd;
    end
  endtask

  // Returns at the negedge of the accepting cycle (or after the bound).
  task automatic wait_accept(input bit p, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = p ? (bus.p1_req_valid & bus.p1_req_ready) : (bus.p0_req_valid & bus.p0_req_ready);
    end
    check_val(tag, got, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int  n0, n1;
  bit  a0, a1, got;

  initial begin
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    bus.ram_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single read from port 0
    @(posedge clk); #1 drive(0, 1, 0, 10'h010, '0, '0);
    wait_accept(0, "t1_accept");
    @(posedge clk); #1 drive(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check_val("t1_rvalid", {bus.p1_rvalid, bus.p0_rvalid}, 2'b01);
    check_val("t1_rdata", bus.p0_rdata, 32'hDEADBEEF);

    // Byte write from port 1, then read back
    @(posedge clk); #1 drive(1, 1, 1, 10'h020, 4'b0101, 32'hAABBCCDD);
    wait_accept(1, "t2_wr_accept");
    check_val("t2_wstrb", bus.ram_wstrb, 32'h00FF00FF);
    @(posedge clk); #1 drive(1, 1, 0, 10'h020, '0, '0);
    wait_accept(1, "t2_rd_accept");
    @(posedge clk); #1 drive(1, 0, 0, '0, '0, '0);
    @(negedge clk);
    check_val("t2_rdata", bus.p1_rdata, 32'h11BB33DD);

    // Round-robin contention: 6 cycles of both ports reading
    @(posedge clk); #1 drive(0, 1, 0, 10'h010, '0, '0); drive(1, 1, 0, 10'h020, '0, '0);
    n0 = 0; n1 = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 6) check_val("rr_grant", {bus.p1_req_ready, bus.p0_req_ready}, (k % 2 == 1) ? 2'b10 : 2'b01);
      n0 += int'(bus.p0_rvalid);
      n1 += int'(bus.p1_rvalid);
      if (k == 5) begin
        @(posedge clk); #1 drive(0, 0, 0, '0, '0, '0); drive(1, 0, 0, '0, '0, '0);
      end
    end
    check_val("rr_rv0_cnt", n0, 3);
    check_val("rr_rv1_cnt", n1, 3);

    // Fixed priority contention on the second instance
    @(posedge clk); #1 drive(0, 1, 0, 10'h011, '0, '0); drive(1, 1, 0, 10'h021, '0, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("fix_p0_ready", bus_f.p0_req_ready, 1);
      check_val("fix_p1_ready", bus_f.p1_req_ready, 0);
    end
    @(posedge clk); #1 drive(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check_val("fix_p1_after", bus_f.p1_req_ready, 1);
    @(posedge clk); #1 drive(1, 0, 0, '0, '0, '0);

    // Backpressure with a read already pending
    @(posedge clk); #1 drive(0, 1, 0, 10'h010, '0, '0);
    wait_accept(0, "bp_first");
    @(posedge clk); #1 bus.ram_ready = 1'b0; drive(0, 1, 0, 10'h020, '0, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("bp_ready", bus.p0_req_ready, 0);
      check_val("bp_cs", bus.ram_cs, 0);
      if (k == 0) check_val("bp_pending_rvalid", bus.p0_rvalid, 1);
    end
    @(posedge clk); #1 bus.ram_ready = 1'b1;
    @(negedge clk);
    check_val("bp_resume", bus.p0_req_ready, 1);
    @(posedge clk); #1 drive(0, 0, 0, '0, '0, '0);

    // Reset right after an accepted read
    @(posedge clk); #1 drive(0, 1, 0, 10'h010, '0, '0);
    wait_accept(0, "rst_rd_accept");
    @(posedge clk); #1 rst = 1'b1; drive(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check_val("rst_t1_rvalid", bus.p0_rvalid, 0);
    @(posedge clk); #1 rst = 1'b0; drive(0, 1, 0, 10'h010, '0, '0); drive(1, 1, 0, 10'h020, '0, '0);
    @(negedge clk);
    check_val("rst_t2_rvalid", bus.p0_rvalid, 0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.p0_req_ready | bus.p1_req_ready) begin
        got = 1'b1;
        check_val("rst_first_win", {bus.p1_req_ready, bus.p0_req_ready}, 2'b01);
      end
    end
    check_val("rst_any_grant", got, 1);
    @(posedge clk); #1 drive(0, 0, 0, '0, '0, '0); drive(1, 0, 0, '0, '0, '0);

    // Random mixed traffic, requests held until accepted
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      a0 = bus.p0_req_valid & bus.p0_req_ready;
      a1 = bus.p1_req_valid & bus.p1_req_ready;
      @(posedge clk); #1;
      if (!bus.p0_req_valid || a0)
        drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'(10'h040 + $urandom_range(0, 7)),
              BW'($urandom), DW'($urandom));
      if (!bus.p1_req_valid || a1)
        drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'(10'h040 + $urandom_range(0, 7)),
              BW'($urandom), DW'($urandom));
      bus.ram_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    @(posedge clk); #1 drive(0, 0, 0, '0, '0, '0); drive(1, 0, 0, '0, '0, '0); bus.ram_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
